// File: rtl/mc_control_unit_pkg.sv
// Shared types for the RV32I multicycle control FSM: opcodes, state codes, datapath mux encodings.
// Latency: n/a (types only); backpressure: n/a.
package mc_control_unit_pkg;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_I      = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_R      = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_t;

    // Encodings are visible on fsm_state, so keep the order stable.
    typedef enum logic [4:0] {
        S_FETCH      = 5'd0,
        S_DECODE     = 5'd1,
        S_MEMADR     = 5'd2,
        S_MEMREAD    = 5'd3,
        S_MEMWB      = 5'd4,
        S_MEMWRITE   = 5'd5,
        S_EXECUTER   = 5'd6,
        S_EXECUTEI   = 5'd7,
        S_ALUWB      = 5'd8,
        S_BRANCH     = 5'd9,
        S_UNCONDJUMP = 5'd10,
        S_JALR       = 5'd11,
        S_JALR_LINK  = 5'd12,
        S_LUI        = 5'd13,
        S_AUIPC      = 5'd14,
        S_TRAP       = 5'd15
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SRC_A_PC    = 2'b00,
        SRC_A_OLDPC = 2'b01,
        SRC_A_RS1   = 2'b10
    } alu_src_a_e;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_FOUR = 2'b10
    } alu_src_b_e;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEMDATA   = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_e;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_BRCMP  = 3'b001,
        ALU_RTYPE  = 3'b010,
        ALU_ITYPE  = 3'b011,
        ALU_PASS_B = 3'b100
    } alu_op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/mc_control_unit_branch_cond_eval.sv
// Branch condition evaluator: funct3 plus ALU compare flags -> taken / illegal encoding.
// Latency: combinational; backpressure: none.
module mc_control_unit_branch_cond_eval
    import mc_control_unit_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       lt_flag,
    input  logic       ltu_flag,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero_flag;
            F3_BNE:  taken = ~zero_flag;
            F3_BLT:  taken = lt_flag;
            F3_BGE:  taken = ~lt_flag;
            F3_BLTU: taken = ltu_flag;
            F3_BGEU: taken = ~ltu_flag;
            // 010 and 011 have no branch meaning in RV32I
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM with req/ready memory handshake, wait timeout and sticky trap.
// Latency: R/I/store/JAL 4, load/JALR 5, branch 3 cycles at zero wait; memory stalls hold the state.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero_flag,
    input  logic       lt_flag,
    input  logic       ltu_flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_update,
    output logic       pc_src,
    output logic       mem_write,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [1:0] result_src,
    output logic [4:0] fsm_state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    ctrl_state_e      state;
    ctrl_state_e      state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             br_taken;
    logic             br_illegal;
    logic             timeout_hit;
    logic             trap_illegal;
    logic             trap_timeout;

    mc_control_unit_branch_cond_eval u_branch_cond (
        .funct3    (funct3),
        .zero_flag (zero_flag),
        .lt_flag   (lt_flag),
        .ltu_flag  (ltu_flag),
        .taken     (br_taken),
        .illegal   (br_illegal)
    );

    // Only consulted when mem_ready is low, so a late completion always beats the timeout.
    assign timeout_hit = (TIMEOUT_CYC != 0) && (wait_cnt == WAIT_LAST) && !mem_ready;
    assign fsm_state   = state;

    always_comb begin
        state_next   = state;
        trap_illegal = 1'b0;
        trap_timeout = 1'b0;
        case (state)
            S_FETCH: begin
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    state_next   = S_TRAP;
                    trap_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_JAL:              state_next = S_UNCONDJUMP;
                    OP_JALR:             state_next = S_JALR;
                    OP_R:                state_next = S_EXECUTER;
                    OP_I:                state_next = S_EXECUTEI;
                    OP_LOAD, OP_STORE:   state_next = S_MEMADR;
                    OP_BRANCH:           state_next = S_BRANCH;
                    OP_LUI:              state_next = S_LUI;
                    OP_AUIPC:            state_next = S_AUIPC;
                    default: begin
                        state_next   = S_TRAP;
                        trap_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_STORE) begin
                    state_next = S_MEMWRITE;
                end else begin
                    state_next = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout_hit) begin
                    state_next   = S_TRAP;
                    trap_timeout = 1'b1;
                end
            end
            S_MEMWRITE: begin
                if (mem_ready) begin
                    state_next = S_FETCH;
                end else if (timeout_hit) begin
                    state_next   = S_TRAP;
                    trap_timeout = 1'b1;
                end
            end
            S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC,
            S_UNCONDJUMP, S_JALR_LINK: state_next = S_ALUWB;
            S_JALR:                    state_next = S_JALR_LINK;
            S_ALUWB, S_MEMWB:          state_next = S_FETCH;
            S_BRANCH: begin
                if (br_illegal) begin
                    state_next   = S_TRAP;
                    trap_illegal = 1'b1;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_FETCH;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state <= state_next;
            // Staying in a requesting state implies the memory has not answered yet.
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (mem_req && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (trap_illegal) begin
                illegal_op <= 1'b1;
            end
            if (trap_timeout) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        pc_src     = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        // Strobes stay quiet while reset is held so the memory port sees no request.
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_update  = 1'b1;
                        alu_src_a  = SRC_A_PC;
                        alu_src_b  = SRC_B_FOUR;
                        result_src = RES_ALURESULT;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                end
                S_MEMADR: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_MEMDATA;
                end
                S_EXECUTER: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_RTYPE;
                end
                S_EXECUTEI: begin
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ITYPE;
                end
                S_LUI: begin
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_PASS_B;
                end
                S_AUIPC: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                end
                S_ALUWB: begin
                    reg_write  = 1'b1;
                    result_src = RES_ALUOUT;
                end
                S_UNCONDJUMP: begin
                    // Jump target was latched into ALUOut during DECODE.
                    pc_update  = 1'b1;
                    result_src = RES_ALUOUT;
                    alu_src_a  = SRC_A_OLDPC;
                    alu_src_b  = SRC_B_FOUR;
                end
                S_JALR: begin
                    pc_update  = 1'b1;
                    result_src = RES_ALURESULT;
                    alu_src_a  = SRC_A_RS1;
                    alu_src_b  = SRC_B_IMM;
                end
                S_JALR_LINK: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_FOUR;
                end
                S_BRANCH: begin
                    branch    = 1'b1;
                    pc_src    = br_taken;
                    alu_src_a = SRC_A_RS1;
                    alu_src_b = SRC_B_RS2;
                    alu_op    = ALU_BRCMP;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: state walks, memory stalls, branch conditions, traps and reset.
module tb_mc_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       zero_flag = 1'b0;
    logic       lt_flag = 1'b0;
    logic       ltu_flag = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, adr_src, ir_write, reg_write, pc_update, pc_src, mem_write, branch;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_op;
    logic [4:0] fsm_state;
    logic       illegal_op, mem_timeout;

    always #5 clk = ~clk;

    mc_control_unit #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct3      (funct3),
        .zero_flag   (zero_flag),
        .lt_flag     (lt_flag),
        .ltu_flag    (ltu_flag),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .pc_update   (pc_update),
        .pc_src      (pc_src),
        .mem_write   (mem_write),
        .branch      (branch),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .result_src  (result_src),
        .fsm_state   (fsm_state),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    localparam int ST_FETCH = 0, ST_DECODE = 1, ST_MEMADR = 2, ST_MEMREAD = 3, ST_MEMWB = 4;
    localparam int ST_MEMWRITE = 5, ST_EXECUTER = 6, ST_EXECUTEI = 7, ST_ALUWB = 8, ST_BRANCH = 9;
    localparam int ST_UNCONDJUMP = 10, ST_JALR = 11, ST_JALR_LINK = 12, ST_LUI = 13, ST_AUIPC = 14;
    localparam int ST_TRAP = 15;

    localparam logic [6:0] OPC_LOAD = 7'b0000011, OPC_I = 7'b0010011, OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_STORE = 7'b0100011, OPC_R = 7'b0110011, OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011, OPC_JALR = 7'b1100111, OPC_JAL = 7'b1101111;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_seq [$];

    logic [2:0] bf3  [6] = '{3'b001, 3'b111, 3'b000, 3'b100, 3'b101, 3'b110};
    logic       bz   [6] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};
    logic       blt  [6] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1,   1'b0};
    logic       bltu [6] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b0,   1'b1};
    logic       btk  [6] = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first FETCH cycle, one time unit after the edge.
    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Zero-wait instruction walk; exp_seq holds the state of every cycle from FETCH on.
    task automatic run_seq(input string tag, input logic [6:0] op, input int exp_mw);
        int mw;
        mw = 0;
        opcode    = op;
        mem_ready = 1'b1;
        do_reset();
        #1;
        for (int i = 0; i < exp_seq.size(); i++) begin
            if (i > 0) begin
                tick();
                #1;
            end
            chk($sformatf("%s_st%0d", tag, i), 32'(fsm_state), 32'(exp_seq[i]));
            if (mem_write) mw++;
        end
        chk($sformatf("%s_mem_write_cycles", tag), 32'(mw), 32'(exp_mw));
    endtask

    initial begin
        int rw_cnt, rw_cyc, rd_cyc, req_lo, fetch_cyc, irw, pcu;

        // Reset held: all strobes and muxes 0, state FETCH, flags clear.
        tick();
        tick();
        #1;
        chk("rst_outputs", 32'({mem_req, adr_src, ir_write, reg_write, pc_update, pc_src, mem_write,
                                branch, alu_src_a, alu_src_b, alu_op, result_src}), 0);
        chk("rst_state", 32'(fsm_state), ST_FETCH);
        chk("rst_flags", 32'({illegal_op, mem_timeout}), 0);

        // R-type add
        exp_seq = '{ST_FETCH, ST_DECODE, ST_EXECUTER, ST_ALUWB};
        opcode = OPC_R;
        mem_ready = 1'b1;
        do_reset();
        #1;
        rw_cnt = 0;
        rw_cyc = 0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) begin
                tick();
                #1;
            end
            chk($sformatf("r_st%0d", c), 32'(fsm_state), 32'(exp_seq[c-1]));
            if (reg_write) begin
                rw_cnt++;
                rw_cyc = c;
            end
            if (c == 1) chk("r_fetch_ctl", 32'({ir_write, pc_update, alu_src_b, result_src}), 32'b1_1_10_10);
            if (c == 2) chk("r_decode_src", 32'({alu_src_a, alu_src_b, alu_op}), 32'b01_01_000);
            if (c == 3) chk("r_exec_aluop", 32'({alu_src_a, alu_src_b, alu_op}), 32'b10_00_010);
        end
        chk("r_reg_write_count", 32'(rw_cnt), 1);
        chk("r_reg_write_cycle", 32'(rw_cyc), 4);
        tick();
        #1;
        chk("r_back_to_fetch", 32'(fsm_state), ST_FETCH);

        // Load with three stalled cycles in MEMREAD
        opcode = OPC_LOAD;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        chk("ld_memadr", 32'(fsm_state), ST_MEMADR);
        rd_cyc = 0;
        req_lo = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            mem_ready = (i == 3);
            #1;
            if (fsm_state != 5'(ST_MEMREAD)) break;
            rd_cyc++;
            if (!mem_req || !adr_src) req_lo++;
        end
        chk("ld_memread_cycles", 32'(rd_cyc), 4);
        chk("ld_req_dropped", 32'(req_lo), 0);
        chk("ld_memwb", 32'(fsm_state), ST_MEMWB);
        chk("ld_memwb_ctl", 32'({reg_write, result_src}), 32'b1_01);
        tick();
        #1;
        chk("ld_back_to_fetch", 32'(fsm_state), ST_FETCH);

        // Branch condition table, back to back
        opcode = OPC_BRANCH;
        mem_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            funct3    = bf3[k];
            zero_flag = bz[k];
            lt_flag   = blt[k];
            ltu_flag  = bltu[k];
            #1;
            chk($sformatf("br%0d_fetch", k), 32'(fsm_state), ST_FETCH);
            tick();
            tick();
            #1;
            chk($sformatf("br%0d_state", k), 32'(fsm_state), ST_BRANCH);
            chk($sformatf("br%0d_pc_src", k), 32'(pc_src), 32'(btk[k]));
            chk($sformatf("br%0d_ctl", k), 32'({branch, pc_update, alu_src_a, alu_src_b, alu_op}),
                32'b1_0_10_00_001);
            tick();
        end
        funct3 = 3'b010;
        zero_flag = 1'b1;
        #1;
        tick();
        tick();
        #1;
        chk("br_f3_010_not_taken", 32'(pc_src), 0);
        tick();
        #1;
        chk("br_f3_010_trap", 32'(fsm_state), ST_TRAP);
        chk("br_f3_010_flags", 32'({illegal_op, mem_timeout}), 32'b10);
        tick();
        #1;
        chk("br_trap_sticky", 32'({fsm_state, mem_req}), 32'({5'(ST_TRAP), 1'b0}));

        // Fetch timeout
        opcode = OPC_R;
        mem_ready = 1'b0;
        do_reset();
        #1;
        fetch_cyc = 0;
        irw = 0;
        for (int i = 0; i < 40; i++) begin
            if (fsm_state != 5'(ST_FETCH)) break;
            fetch_cyc++;
            if (ir_write) irw++;
            tick();
            #1;
        end
        chk("to_fetch_cycles", 32'(fetch_cyc), 16);
        chk("to_ir_write_seen", 32'(irw), 0);
        chk("to_state", 32'(fsm_state), ST_TRAP);
        chk("to_flags", 32'({illegal_op, mem_timeout}), 32'b01);

        // mem_ready on the last allowed wait cycle beats the timeout
        mem_ready = 1'b0;
        do_reset();
        #1;
        chk("edge_flags_cleared", 32'({illegal_op, mem_timeout}), 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            #1;
        end
        mem_ready = 1'b1;
        #1;
        chk("edge_ir_write", 32'(ir_write), 1);
        tick();
        #1;
        chk("edge_decode", 32'(fsm_state), ST_DECODE);
        chk("edge_no_timeout", 32'(mem_timeout), 0);

        // Illegal opcode, then reset out of TRAP
        opcode = 7'b0000000;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        #1;
        chk("ill_trap", 32'(fsm_state), ST_TRAP);
        chk("ill_flags", 32'({illegal_op, mem_timeout}), 32'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("ill_reset_state", 32'(fsm_state), ST_FETCH);
        chk("ill_reset_flags", 32'({illegal_op, mem_timeout}), 0);

        // JALR
        opcode = OPC_JALR;
        mem_ready = 1'b1;
        do_reset();
        tick();
        tick();
        #1;
        pcu = 0;
        chk("jalr_state", 32'(fsm_state), ST_JALR);
        chk("jalr_ctl", 32'({pc_update, alu_src_a, alu_src_b, result_src}), 32'b1_10_01_10);
        if (pc_update) pcu++;
        tick();
        #1;
        chk("jalr_link_state", 32'(fsm_state), ST_JALR_LINK);
        chk("jalr_link_ctl", 32'({reg_write, alu_src_a, alu_src_b}), 32'b0_01_10);
        if (pc_update) pcu++;
        tick();
        #1;
        chk("jalr_aluwb", 32'({fsm_state, reg_write}), 32'({5'(ST_ALUWB), 1'b1}));
        if (pc_update) pcu++;
        chk("jalr_pc_update_cycles", 32'(pcu), 1);
        tick();
        #1;
        chk("jalr_back_to_fetch", 32'(fsm_state), ST_FETCH);

        // Remaining zero-wait paths
        exp_seq = '{ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMWRITE, ST_FETCH};
        run_seq("st", OPC_STORE, 1);
        exp_seq = '{ST_FETCH, ST_DECODE, ST_UNCONDJUMP, ST_ALUWB, ST_FETCH};
        run_seq("jal", OPC_JAL, 0);
        exp_seq = '{ST_FETCH, ST_DECODE, ST_EXECUTEI, ST_ALUWB, ST_FETCH};
        run_seq("itype", OPC_I, 0);
        exp_seq = '{ST_FETCH, ST_DECODE, ST_AUIPC, ST_ALUWB, ST_FETCH};
        run_seq("auipc", OPC_AUIPC, 0);
        exp_seq = '{ST_FETCH, ST_DECODE, ST_LUI};
        run_seq("lui", OPC_LUI, 0);
        chk("lui_ctl", 32'({alu_src_b, alu_op}), 32'b01_100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
